// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : alu_multicycle
// Description : Handshaked ALU with the classic eight-operation select code.
//               Logic, add, sub and divide-by-zero finish in one cycle;
//               multiply (shift-add) and divide (restoring) iterate one bit
//               per cycle. Each result carries its own carry/zero/div_by_zero
//               flags.
// Ports       : clk, rst (async, active high)
//               in_valid / in_ready       - request handshake
//               a, b, alu_select          - operands and operation code
//               out_valid / out_ready     - result handshake
//               alu_out, carry, zero,
//               div_by_zero               - result and flags (held in DONE)
//               busy                      - block is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry,
    output logic             zero,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int                 C_CNT_W    = $clog2(WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(WIDTH - 1);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_CALC = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_is_div;
    // Shared iteration registers:
    //   mult: r_hi = upper accumulator, r_lo = multiplier (shifts out LSB first)
    //   div : r_hi = partial remainder, r_lo = dividend shifting into quotient
    //   r_opnd holds the multiplicand (mult) or the divisor (div).
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opnd;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_alu_out;
    logic               r_carry;
    logic               r_zero;
    logic               r_dbz;

    // ---------------- single-cycle datapath (operates on live inputs) -------
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH-1:0]   w_fast_res;
    logic               w_fast_carry;
    logic               w_fast_dbz;
    logic               w_go_calc;

    assign w_add = {1'b0, a} + {1'b0, b};
    // Bit WIDTH of the extended difference is the borrow (a < b).
    assign w_sub = {1'b0, a} - {1'b0, b};

    always_comb begin
        w_fast_res   = '0;
        w_fast_carry = 1'b0;
        w_fast_dbz   = 1'b0;
        w_go_calc    = 1'b0;
        case (alu_select)
            3'b000: w_fast_res = a & b;
            3'b001: w_fast_res = a | b;
            3'b010: w_fast_res = a ^ b;
            3'b011: w_fast_res = ~(a | b);
            3'b100: begin
                w_fast_res   = w_add[WIDTH-1:0];
                w_fast_carry = w_add[WIDTH];
            end
            3'b101: begin
                w_fast_res   = w_sub[WIDTH-1:0];
                w_fast_carry = w_sub[WIDTH];
            end
            3'b110: w_go_calc = 1'b1;
            default: begin
                // Divide: a zero divisor short-circuits to all ones.
                if (b == '0) begin
                    w_fast_res = '1;
                    w_fast_dbz = 1'b1;
                end else begin
                    w_go_calc = 1'b1;
                end
            end
        endcase
    end

    // ---------------- one iteration step of mult / div ----------------------
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_trial;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_diff;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;

    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_div_trial = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_trial >= {1'b0, r_opnd});
    // When the subtraction is taken the true difference is below the divisor,
    // so the low WIDTH bits of the trial are enough to form it.
    assign w_div_diff  = w_div_trial[WIDTH-1:0] - r_opnd;

    always_comb begin
        if (r_is_div) begin
            w_step_hi = w_div_ge ? w_div_diff : w_div_trial[WIDTH-1:0];
            w_step_lo = {r_lo[WIDTH-2:0], w_div_ge};
        end else begin
            w_step_hi = w_mul_sum[WIDTH:1];
            w_step_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // ---------------- control FSM and output registers ----------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= C_ST_IDLE;
            r_cnt       <= '0;
            r_is_div    <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_opnd      <= '0;
            r_out_valid <= 1'b0;
            r_alu_out   <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (in_valid) begin
                        if (w_go_calc) begin
                            r_state  <= C_ST_CALC;
                            r_cnt    <= C_CNT_LOAD;
                            r_is_div <= alu_select[0];
                            r_hi     <= '0;
                            r_lo     <= alu_select[0] ? a : b;
                            r_opnd   <= alu_select[0] ? b : a;
                        end else begin
                            r_state     <= C_ST_DONE;
                            r_out_valid <= 1'b1;
                            r_alu_out   <= w_fast_res;
                            r_carry     <= w_fast_carry;
                            r_zero      <= (w_fast_res == '0);
                            r_dbz       <= w_fast_dbz;
                        end
                    end
                end
                C_ST_CALC: begin
                    r_hi <= w_step_hi;
                    r_lo <= w_step_lo;
                    if (r_cnt == '0) begin
                        // Final step: publish the values this step produces.
                        r_state     <= C_ST_DONE;
                        r_out_valid <= 1'b1;
                        r_alu_out   <= w_step_lo;
                        r_carry     <= r_is_div ? 1'b0 : (|w_step_hi);
                        r_zero      <= (w_step_lo == '0);
                        r_dbz       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_W'(1);
                    end
                end
                C_ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= C_ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == C_ST_IDLE);
    assign busy        = (r_state != C_ST_IDLE);
    assign out_valid   = r_out_valid;
    assign alu_out     = r_alu_out;
    assign carry       = r_carry;
    assign zero        = r_zero;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_multicycle
// Description : Self-checking bench for alu_multicycle. Expected results come
//               from a behavioural model (native wide arithmetic), are queued
//               when a request is driven and compared when out_valid appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

    localparam int W = 20;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         d;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   alu_select;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out;
    logic         carry;
    logic         zero;
    logic         div_by_zero;
    logic         busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    alu_multicycle #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .alu_select  (alu_select),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_out     (alu_out),
        .carry       (carry),
        .zero        (zero),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [2:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        logic [W:0]   s1;
        logic [2*W-1:0] p;
        e     = '0;
        e.lat = 1;
        case (s)
            3'd0: e.res = x & y;
            3'd1: e.res = x | y;
            3'd2: e.res = x ^ y;
            3'd3: e.res = ~(x | y);
            3'd4: begin
                s1    = {1'b0, x} + {1'b0, y};
                e.res = s1[W-1:0];
                e.c   = s1[W];
            end
            3'd5: begin
                e.res = x - y;
                e.c   = (x < y);
            end
            3'd6: begin
                p     = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                e.res = p[W-1:0];
                e.c   = (p[2*W-1:W] != '0);
                e.lat = W + 1;
            end
            default: begin
                if (y == '0) begin
                    e.res = '1;
                    e.d   = 1'b1;
                end else begin
                    e.res = x / y;
                    e.lat = W + 1;
                end
            end
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Drive one request; returns after the accept edge with inputs scrambled.
    task automatic send(input logic [2:0] s, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        in_valid   = 1'b1;
        a          = x;
        b          = y;
        alu_select = s;
        if (push) sb.push_back(model(s, x, y));
        @(posedge clk); #1;
        in_valid   = 1'b0;
        a          = W'($urandom);
        b          = W'($urandom);
        alu_select = 3'($urandom);
    endtask

    // Cycles from accept until out_valid; -1 on timeout.
    task automatic wait_out(output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        if (out_valid !== 1'b1) cyc = -1;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; alu_select = '0;
        #1;
        n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (alu_out !== '0)       begin n_fail++; $display("FAIL reset_alu_out: got %h want 0", alu_out); end
        n_checks++; if ({carry, zero, div_by_zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {carry, zero, div_by_zero}); end
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_busy_ready: got busy=%b in_ready=%b want 0/1", busy, in_ready); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Table-driven single-cycle ops: logic, add and sub (incl. carry/borrow).
    task automatic test_single_cycle();
        logic [2:0]   ts [8] = '{3'd4, 3'd5, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        logic [W-1:0] ta [8] = '{20'hFFFFF, 20'd5, 20'd7, 20'hA5A5A, 20'h12340, 20'hFFFFF, 20'h00000, 20'h12345};
        logic [W-1:0] tb [8] = '{20'h00001, 20'd7, 20'd5, 20'h0F0F0, 20'h00005, 20'hFFFFF, 20'h00000, 20'h54321};
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            int   cyc;
            send(ts[i], ta[i], tb[i], 1'b1);
            wait_out(cyc);
            e = sb.pop_front();
            n_checks++; if (cyc != e.lat) begin n_fail++; $display("FAIL single_latency[%0d]: got %0d want %0d", i, cyc, e.lat); end
            n_checks++; if (alu_out !== e.res) begin n_fail++; $display("FAIL single_result[%0d]: got %h want %h", i, alu_out, e.res); end
            n_checks++; if ({carry, zero, div_by_zero} !== {e.c, e.z, e.d}) begin n_fail++; $display("FAIL single_flags[%0d]: got %b want %b", i, {carry, zero, div_by_zero}, {e.c, e.z, e.d}); end
            ack();
        end
    endtask

    task automatic test_mult();
        logic [W-1:0] ta [4] = '{20'h00400, 20'd123, 20'hFFFFF, 20'h00000};
        logic [W-1:0] tb [4] = '{20'h00400, 20'd456, 20'h00003, 20'h12345};
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            int   cyc;
            send(3'd6, ta[i], tb[i], 1'b1);
            n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mult_busy[%0d]: got busy=%b out_valid=%b want 1/0", i, busy, out_valid); end
            wait_out(cyc);
            e = sb.pop_front();
            n_checks++; if (cyc != e.lat) begin n_fail++; $display("FAIL mult_latency[%0d]: got %0d want %0d", i, cyc, e.lat); end
            n_checks++; if (alu_out !== e.res) begin n_fail++; $display("FAIL mult_result[%0d]: got %h want %h", i, alu_out, e.res); end
            n_checks++; if ({carry, zero, div_by_zero} !== {e.c, e.z, e.d}) begin n_fail++; $display("FAIL mult_flags[%0d]: got %b want %b", i, {carry, zero, div_by_zero}, {e.c, e.z, e.d}); end
            ack();
        end
    endtask

    task automatic test_div();
        logic [W-1:0] ta [7] = '{20'd100, 20'd100, 20'hFFFFF, 20'd3, 20'h0, 20'h0, 20'h0};
        logic [W-1:0] tb [7] = '{20'd7,   20'd0,   20'd1,    20'd9, 20'h0, 20'h0, 20'h0};
        for (int i = 4; i < 7; i++) begin
            ta[i] = W'($urandom);
            tb[i] = W'($urandom_range(1, 4095));
        end
        for (int i = 0; i < 7; i++) begin
            exp_t e;
            int   cyc;
            send(3'd7, ta[i], tb[i], 1'b1);
            wait_out(cyc);
            e = sb.pop_front();
            n_checks++; if (cyc != e.lat) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, cyc, e.lat); end
            n_checks++; if (alu_out !== e.res) begin n_fail++; $display("FAIL div_result[%0d]: %h/%h got %h want %h", i, ta[i], tb[i], alu_out, e.res); end
            n_checks++; if ({carry, zero, div_by_zero} !== {e.c, e.z, e.d}) begin n_fail++; $display("FAIL div_flags[%0d]: got %b want %b", i, {carry, zero, div_by_zero}, {e.c, e.z, e.d}); end
            ack();
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   cyc;
        send(3'd1, 20'hF0F0F, 20'h0F0F0, 1'b1);
        wait_out(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL bp_latency: got %0d want 1", cyc); end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in_valid = 1'b1; alu_select = 3'd0; a = 20'h11111; b = 20'h22222;
            end
            n_checks++; if (alu_out !== e.res || {carry, zero, div_by_zero} !== {e.c, e.z, e.d} || out_valid !== 1'b1)
                begin n_fail++; $display("FAIL bp_hold[%0d]: got %h/%b want %h/%b", i, alu_out, {carry, zero, div_by_zero}, e.res, {e.c, e.z, e.d}); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        ack();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_req: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        int   cyc;
        send(3'd6, 20'd3, 20'd5, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || alu_out !== '0 || {carry, zero, div_by_zero} !== 3'b000)
            begin n_fail++; $display("FAIL rst_mid_outputs: got v=%b out=%h flags=%b want 0/0/000", out_valid, alu_out, {carry, zero, div_by_zero}); end
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got in_ready=%b busy=%b want 1/0", in_ready, busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        send(3'd3, 20'h0, 20'h0, 1'b1);
        wait_out(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc != 1 || alu_out !== e.res) begin n_fail++; $display("FAIL rst_mid_nor: got lat=%0d out=%h want 1/%h", cyc, alu_out, e.res); end
        ack();
        repeat (25) begin
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale: got out_valid=%b want 0", out_valid); end
        end
    endtask

    // in_valid and out_ready held high: one accept every second cycle.
    task automatic test_back_to_back();
        int n_out = 0;
        int n_in  = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid === 1'b1) begin
                exp_t e;
                n_out++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected_output: got out=%h want none", alu_out);
                end else begin
                    e = sb.pop_front();
                    if (alu_out !== e.res || {carry, zero, div_by_zero} !== {e.c, e.z, e.d}) begin
                        n_fail++; $display("FAIL b2b_result: got %h/%b want %h/%b", alu_out, {carry, zero, div_by_zero}, e.res, {e.c, e.z, e.d});
                    end
                end
            end
            if (in_ready === 1'b1 && i < 10) begin
                alu_select = 3'(n_in % 6);
                a          = W'($urandom);
                b          = W'($urandom);
                sb.push_back(model(alu_select, a, b));
                n_in++;
            end
            if (i == 10) in_valid = 1'b0;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        n_checks++; if (n_out != 5 || n_in != 5) begin n_fail++; $display("FAIL b2b_rate: got %0d outputs %0d accepts want 5/5", n_out, n_in); end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d pending want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mult();
        test_div();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
